// File: rtl/ttc_lite_pkg29.sv
// ---------------------------------------------------------------------------
// ttc_lite_pkg29
// Shared constants for the lite triple-timer counter slice:
//   - control-register bit positions
//   - counter width and the free-running limit (16'hFFFF)
//   - prescaler counter width and the prescale period mask helper
// Optional feature macro used by the slice: TTC_PRESCALE_EN
// ---------------------------------------------------------------------------
package ttc_lite_pkg29;

  localparam int CNT_W      = 16;
  localparam int CTRL_W     = 4;   // stored control bits; restart is not stored
  localparam int N_MATCH    = 3;
  localparam int CLK_CTRL_W = 4;

  localparam int BIT_DISABLE  = 0;
  localparam int BIT_INTERVAL = 1;
  localparam int BIT_DECREMENT = 2;
  localparam int BIT_MATCH_EN = 3;
  localparam int BIT_RESTART  = 4;

  localparam logic [CNT_W-1:0]  LIMIT_MAX  = 16'hFFFF;
  localparam logic [CTRL_W-1:0] CTRL_RESET = 4'b0001;  // counter stopped

  // Largest divide is 2^(7+1) = 256, so an 8-bit free-running counter suffices.
  localparam int PRESCALE_W = 8;

  // Low (n+1) bits set: a tick fires whenever those bits of the prescale
  // counter are all ones, i.e. once every 2^(n+1) cycles.
  function automatic logic [PRESCALE_W-1:0] prescale_mask(input logic [2:0] n);
    return (PRESCALE_W'(2) << n) - PRESCALE_W'(1);
  endfunction

endpackage

// File: rtl/ttc_prescaler_lite29.sv
// ---------------------------------------------------------------------------
// ttc_prescaler_lite29
// Produces the counter tick. With prescaling disabled every cycle is a tick;
// with it enabled a tick occurs every 2^(N+1) cycles.
// Ports:
//   pclk29, n_p_reset29 : clock, asynchronous active-low reset
//   run_i               : counter enabled; the prescaler holds when low
//   clear_i             : restart the prescale period from zero
//   prescale_en_i       : prescaling enabled
//   prescale_n_i        : exponent N
//   tick_o              : counter advance strobe
// ---------------------------------------------------------------------------
module ttc_prescaler_lite29
  import ttc_lite_pkg29::*;
(
  input  logic       pclk29,
  input  logic       n_p_reset29,
  input  logic       run_i,
  input  logic       clear_i,
  input  logic       prescale_en_i,
  input  logic [2:0] prescale_n_i,
  output logic       tick_o
);

  logic [PRESCALE_W-1:0] cnt_q, cnt_d;
  logic [PRESCALE_W-1:0] mask;

  always_comb begin
    mask   = prescale_mask(prescale_n_i);
    // The counter free-runs over 256 states, a multiple of every period, so
    // it never needs reloading on a tick.
    tick_o = !prescale_en_i || (&(cnt_q | ~mask));
    cnt_d  = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (run_i && prescale_en_i) begin
      cnt_d = cnt_q + PRESCALE_W'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of block ordering.
  always_ff @(posedge pclk29 or negedge n_p_reset29) begin
    if (!n_p_reset29) cnt_q <= '0;
    else              cnt_q <= cnt_d;
  end

endmodule

// File: rtl/ttc_counter_lite29.sv
// ---------------------------------------------------------------------------
// ttc_counter_lite29
// Single 16-bit timer counter with interval/overflow wrap, three match
// comparators and a self-clearing restart. All interrupt outputs are
// registered one-cycle pulses.
// Optional feature: TTC_PRESCALE_EN adds a clock-control register
// (bit0 prescale enable, bits[3:1] N) and the prescaler sub-module.
// Ports:
//   pclk29, n_p_reset29   : clock, asynchronous active-low reset
//   pwdata29              : APB write data
//   cntr_ctrl_reg_sel29   : control register write strobe
//   interval_reg_sel29    : interval register write strobe
//   match_reg_sel29[2:0]  : match1..3 register write strobes
//   clk_ctrl_reg_sel29    : clock-control write strobe (prescale build only)
//   interval_intr29       : interval wrap pulse
//   match_intr29[3:1]     : match pulses
//   overflow_intr29       : overflow wrap pulse
//   restart29             : restart pulse
//   count_val_out29       : current count
//   cntr_ctrl_reg_out29   : control bits [3:0]
// ---------------------------------------------------------------------------
module ttc_counter_lite29
  import ttc_lite_pkg29::*;
(
  input  logic              pclk29,
  input  logic              n_p_reset29,
  input  logic [15:0]       pwdata29,
  input  logic              cntr_ctrl_reg_sel29,
  input  logic              interval_reg_sel29,
  input  logic [2:0]        match_reg_sel29,
  input  logic              clk_ctrl_reg_sel29,
  output logic              interval_intr29,
  output logic [3:1]        match_intr29,
  output logic              overflow_intr29,
  output logic              restart29,
  output logic [15:0]       count_val_out29,
  output logic [3:0]        cntr_ctrl_reg_out29
);

  logic [CTRL_W-1:0]              ctrl_q, ctrl_d;
  logic [CNT_W-1:0]               interval_q, interval_d;
  logic [N_MATCH-1:0][CNT_W-1:0]  match_q, match_d;
  logic [CNT_W-1:0]               count_q, count_d;
  logic                           interval_intr_q, interval_intr_d;
  logic                           overflow_intr_q, overflow_intr_d;
  logic [N_MATCH-1:0]             match_intr_q, match_intr_d;
  logic                           restart_q, restart_d;

  logic             tick;
  logic             restart_req;
  logic             wrap;
  logic [CNT_W-1:0] limit;
  logic [CNT_W-1:0] restart_limit;

  assign restart_req = cntr_ctrl_reg_sel29 && pwdata29[BIT_RESTART];

`ifdef TTC_PRESCALE_EN
  logic [CLK_CTRL_W-1:0] clk_ctrl_q, clk_ctrl_d;

  always_comb begin
    clk_ctrl_d = clk_ctrl_q;
    if (clk_ctrl_reg_sel29) clk_ctrl_d = pwdata29[CLK_CTRL_W-1:0];
  end

  always_ff @(posedge pclk29 or negedge n_p_reset29) begin
    if (!n_p_reset29) clk_ctrl_q <= '0;
    else              clk_ctrl_q <= clk_ctrl_d;
  end

  ttc_prescaler_lite29 u_prescaler (
    .pclk29        (pclk29),
    .n_p_reset29   (n_p_reset29),
    .run_i         (!ctrl_q[BIT_DISABLE]),
    .clear_i       (restart_req),
    .prescale_en_i (clk_ctrl_q[0]),
    .prescale_n_i  (clk_ctrl_q[3:1]),
    .tick_o        (tick)
  );
`else
  // Without prescaling the clock-control strobe has no register behind it.
  logic unused_clk_ctrl_sel;
  assign unused_clk_ctrl_sel = clk_ctrl_reg_sel29;
  assign tick = 1'b1;
`endif

  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // leaves it unassigned, which would otherwise infer a latch.
    ctrl_d          = ctrl_q;
    interval_d      = interval_q;
    match_d         = match_q;
    count_d         = count_q;
    interval_intr_d = 1'b0;
    overflow_intr_d = 1'b0;
    match_intr_d    = '0;
    restart_d       = 1'b0;
    wrap            = 1'b0;

    if (cntr_ctrl_reg_sel29) ctrl_d = pwdata29[CTRL_W-1:0];
    if (interval_reg_sel29)  interval_d = pwdata29;
    for (int n = 0; n < N_MATCH; n++) begin
      if (match_reg_sel29[n]) match_d[n] = pwdata29;
    end

    limit         = ctrl_q[BIT_INTERVAL] ? interval_q : LIMIT_MAX;
    // A restart reloads using the mode bits being written with it.
    restart_limit = pwdata29[BIT_INTERVAL] ? interval_q : LIMIT_MAX;

    if (restart_req) begin
      // Restart beats any coincident tick and suppresses wrap/match pulses.
      restart_d = 1'b1;
      count_d   = pwdata29[BIT_DECREMENT] ? restart_limit : '0;
    end else if (!ctrl_q[BIT_DISABLE] && tick) begin
      if (ctrl_q[BIT_DECREMENT]) begin
        if (count_q == '0) begin
          count_d = limit;
          wrap    = 1'b1;
        end else begin
          count_d = count_q - CNT_W'(1);
        end
      end else begin
        // A count left above a lowered limit runs on to 16'hFFFF and wraps.
        if (count_q == limit || count_q == LIMIT_MAX) begin
          count_d = '0;
          wrap    = 1'b1;
        end else begin
          count_d = count_q + CNT_W'(1);
        end
      end

      if (wrap) begin
        if (ctrl_q[BIT_INTERVAL]) interval_intr_d = 1'b1;
        else                      overflow_intr_d = 1'b1;
      end

      if (ctrl_q[BIT_MATCH_EN]) begin
        for (int n = 0; n < N_MATCH; n++) begin
          match_intr_d[n] = (count_d == match_q[n]);
        end
      end
    end
  end

  // NOTE: count and all registers reset asynchronously; disable resets high
  // so the counter is stopped until software writes the control register.
  always_ff @(posedge pclk29 or negedge n_p_reset29) begin
    if (!n_p_reset29) begin
      ctrl_q          <= CTRL_RESET;
      interval_q      <= '0;
      match_q         <= '0;
      count_q         <= '0;
      interval_intr_q <= 1'b0;
      overflow_intr_q <= 1'b0;
      match_intr_q    <= '0;
      restart_q       <= 1'b0;
    end else begin
      ctrl_q          <= ctrl_d;
      interval_q      <= interval_d;
      match_q         <= match_d;
      count_q         <= count_d;
      interval_intr_q <= interval_intr_d;
      overflow_intr_q <= overflow_intr_d;
      match_intr_q    <= match_intr_d;
      restart_q       <= restart_d;
    end
  end

  assign interval_intr29     = interval_intr_q;
  assign overflow_intr29     = overflow_intr_q;
  assign match_intr29        = match_intr_q;
  assign restart29           = restart_q;
  assign count_val_out29     = count_q;
  assign cntr_ctrl_reg_out29 = ctrl_q;

endmodule

// File: tb/tb_ttc_counter_lite29.sv
// ---------------------------------------------------------------------------
// tb_ttc_counter_lite29
// Directed, table-driven bench for ttc_counter_lite29 plus hand-written
// sequences for decrement wrap, disable hold, zero interval, asynchronous
// reset and the prescaler (TTC_PRESCALE_EN aware).
// ---------------------------------------------------------------------------
module tb_ttc_counter_lite29;

  logic        pclk29 = 1'b0;
  logic        n_p_reset29;
  logic [15:0] pwdata29;
  logic        cntr_ctrl_reg_sel29;
  logic        interval_reg_sel29;
  logic [2:0]  match_reg_sel29;
  logic        clk_ctrl_reg_sel29;
  logic        interval_intr29;
  logic [3:1]  match_intr29;
  logic        overflow_intr29;
  logic        restart29;
  logic [15:0] count_val_out29;
  logic [3:0]  cntr_ctrl_reg_out29;

  int n_checks = 0;
  int n_fail   = 0;

`ifdef TTC_PRESCALE_EN
  localparam int DIV = 4;
`else
  localparam int DIV = 1;
`endif

  ttc_counter_lite29 dut (
    .pclk29              (pclk29),
    .n_p_reset29         (n_p_reset29),
    .pwdata29            (pwdata29),
    .cntr_ctrl_reg_sel29 (cntr_ctrl_reg_sel29),
    .interval_reg_sel29  (interval_reg_sel29),
    .match_reg_sel29     (match_reg_sel29),
    .clk_ctrl_reg_sel29  (clk_ctrl_reg_sel29),
    .interval_intr29     (interval_intr29),
    .match_intr29        (match_intr29),
    .overflow_intr29     (overflow_intr29),
    .restart29           (restart29),
    .count_val_out29     (count_val_out29),
    .cntr_ctrl_reg_out29 (cntr_ctrl_reg_out29)
  );

  always #5 pclk29 = ~pclk29;

  typedef struct {
    logic        ctrl_we;
    logic        int_we;
    logic [2:0]  match_we;
    logic [15:0] wdata;
    logic [15:0] exp_count;
    logic        exp_intv;
    logic        exp_ovf;
    logic [2:0]  exp_match;
    logic        exp_restart;
    logic [3:0]  exp_ctrl;
  } vec_t;

  localparam int N_VEC = 23;
  vec_t vecs [N_VEC];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge pclk29);
    #1;
  endtask

  task automatic drive(input logic c, input logic i, input logic [2:0] m,
                       input logic k, input logic [15:0] d);
    cntr_ctrl_reg_sel29 = c;
    interval_reg_sel29  = i;
    match_reg_sel29     = m;
    clk_ctrl_reg_sel29  = k;
    pwdata29            = d;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 3'b000, 1'b0, 16'h0);
  endtask

  task automatic check_outs(input string tag, input logic [15:0] cnt, input logic intv,
                            input logic ovf, input logic [2:0] mt, input logic rs);
    check({tag, " count"}, 32'(count_val_out29), 32'(cnt));
    check({tag, " interval_intr"}, 32'(interval_intr29), 32'(intv));
    check({tag, " overflow_intr"}, 32'(overflow_intr29), 32'(ovf));
    check({tag, " match_intr"}, 32'(match_intr29), 32'(mt));
    check({tag, " restart"}, 32'(restart29), 32'(rs));
  endtask

  initial begin
    // Fields: ctrl_we, int_we, match_we, wdata | count, intv, ovf, match, restart, ctrl
    // Interval mode, interval = 3, increment: 0,1,2,3,0 ...
    vecs[0]  = '{1'b0, 1'b1, 3'b000, 16'h0003, 16'd0, 1'b0, 1'b0, 3'b000, 1'b0, 4'h1};
    vecs[1]  = '{1'b1, 1'b0, 3'b000, 16'h0012, 16'd0, 1'b0, 1'b0, 3'b000, 1'b1, 4'h2};
    vecs[2]  = '{1'b0, 1'b0, 3'b000, 16'h0000, 16'd1, 1'b0, 1'b0, 3'b000, 1'b0, 4'h2};
    vecs[3]  = '{1'b0, 1'b0, 3'b000, 16'h0000, 16'd2, 1'b0, 1'b0, 3'b000, 1'b0, 4'h2};
    vecs[4]  = '{1'b0, 1'b0, 3'b000, 16'h0000, 16'd3, 1'b0, 1'b0, 3'b000, 1'b0, 4'h2};
    vecs[5]  = '{1'b0, 1'b0, 3'b000, 16'h0000, 16'd0, 1'b1, 1'b0, 3'b000, 1'b0, 4'h2};
    vecs[6]  = '{1'b0, 1'b0, 3'b000, 16'h0000, 16'd1, 1'b0, 1'b0, 3'b000, 1'b0, 4'h2};
    vecs[7]  = '{1'b0, 1'b0, 3'b000, 16'h0000, 16'd2, 1'b0, 1'b0, 3'b000, 1'b0, 4'h2};
    vecs[8]  = '{1'b0, 1'b0, 3'b000, 16'h0000, 16'd3, 1'b0, 1'b0, 3'b000, 1'b0, 4'h2};
    vecs[9]  = '{1'b0, 1'b0, 3'b000, 16'h0000, 16'd0, 1'b1, 1'b0, 3'b000, 1'b0, 4'h2};
    vecs[10] = '{1'b0, 1'b0, 3'b000, 16'h0000, 16'd1, 1'b0, 1'b0, 3'b000, 1'b0, 4'h2};
    vecs[11] = '{1'b0, 1'b0, 3'b000, 16'h0000, 16'd2, 1'b0, 1'b0, 3'b000, 1'b0, 4'h2};
    vecs[12] = '{1'b0, 1'b0, 3'b000, 16'h0000, 16'd3, 1'b0, 1'b0, 3'b000, 1'b0, 4'h2};
    // Restart on the wrap edge: restart wins, no interval pulse.
    vecs[13] = '{1'b1, 1'b0, 3'b000, 16'h0010, 16'd0, 1'b0, 1'b0, 3'b000, 1'b1, 4'h0};
    vecs[14] = '{1'b0, 1'b0, 3'b000, 16'h0000, 16'd1, 1'b0, 1'b0, 3'b000, 1'b0, 4'h0};
    // match1 = match3 = 5, then match enable with restart.
    vecs[15] = '{1'b0, 1'b0, 3'b101, 16'h0005, 16'd2, 1'b0, 1'b0, 3'b000, 1'b0, 4'h0};
    vecs[16] = '{1'b1, 1'b0, 3'b000, 16'h0018, 16'd0, 1'b0, 1'b0, 3'b000, 1'b1, 4'h8};
    vecs[17] = '{1'b0, 1'b0, 3'b000, 16'h0000, 16'd1, 1'b0, 1'b0, 3'b000, 1'b0, 4'h8};
    vecs[18] = '{1'b0, 1'b0, 3'b000, 16'h0000, 16'd2, 1'b0, 1'b0, 3'b000, 1'b0, 4'h8};
    vecs[19] = '{1'b0, 1'b0, 3'b000, 16'h0000, 16'd3, 1'b0, 1'b0, 3'b000, 1'b0, 4'h8};
    vecs[20] = '{1'b0, 1'b0, 3'b000, 16'h0000, 16'd4, 1'b0, 1'b0, 3'b000, 1'b0, 4'h8};
    vecs[21] = '{1'b0, 1'b0, 3'b000, 16'h0000, 16'd5, 1'b0, 1'b0, 3'b101, 1'b0, 4'h8};
    vecs[22] = '{1'b0, 1'b0, 3'b000, 16'h0000, 16'd6, 1'b0, 1'b0, 3'b000, 1'b0, 4'h8};

    n_p_reset29 = 1'b0;
    idle();
    step();
    step();
    check_outs("reset", 16'd0, 1'b0, 1'b0, 3'b000, 1'b0);
    check("reset ctrl", 32'(cntr_ctrl_reg_out29), 32'h1);
    n_p_reset29 = 1'b1;
    step();
    check("stopped after reset count", 32'(count_val_out29), 32'd0);

    for (int v = 0; v < N_VEC; v++) begin
      drive(vecs[v].ctrl_we, vecs[v].int_we, vecs[v].match_we, 1'b0, vecs[v].wdata);
      step();
      check_outs($sformatf("v%0d", v), vecs[v].exp_count, vecs[v].exp_intv,
                 vecs[v].exp_ovf, vecs[v].exp_match, vecs[v].exp_restart);
      check($sformatf("v%0d ctrl", v), 32'(cntr_ctrl_reg_out29), 32'(vecs[v].exp_ctrl));
    end

    // Decrement from 0 in overflow mode: one tick gives 16'hFFFF and one pulse.
    drive(1'b1, 1'b0, 3'b000, 1'b0, 16'h0011);   // restart to 0, stopped
    step();
    check_outs("dec restart", 16'h0000, 1'b0, 1'b0, 3'b000, 1'b1);
    drive(1'b1, 1'b0, 3'b000, 1'b0, 16'h0004);   // decrement, enabled
    step();
    check_outs("dec enable", 16'h0000, 1'b0, 1'b0, 3'b000, 1'b0);
    idle();
    step();
    check_outs("dec wrap", 16'hFFFF, 1'b0, 1'b1, 3'b000, 1'b0);
    step();
    check_outs("dec after wrap", 16'hFFFE, 1'b0, 1'b0, 3'b000, 1'b0);

    // Disable: the count holds and nothing pulses.
    drive(1'b1, 1'b0, 3'b000, 1'b0, 16'h0005);
    step();
    check("disable edge count", 32'(count_val_out29), 32'hFFFD);
    idle();
    for (int k = 0; k < 3; k++) begin
      step();
      check_outs($sformatf("hold%0d", k), 16'hFFFD, 1'b0, 1'b0, 3'b000, 1'b0);
    end

    // Interval register 0: count sits at 0 and interval pulses on every tick.
    drive(1'b0, 1'b1, 3'b000, 1'b0, 16'h0000);
    step();
    drive(1'b1, 1'b0, 3'b000, 1'b0, 16'h0012);
    step();
    check_outs("int0 restart", 16'd0, 1'b0, 1'b0, 3'b000, 1'b1);
    idle();
    step();
    check_outs("int0 tick1", 16'd0, 1'b1, 1'b0, 3'b000, 1'b0);
    step();
    check_outs("int0 tick2", 16'd0, 1'b1, 1'b0, 3'b000, 1'b0);

    // Load 16'h1234 via a decrement restart in interval mode, then reset.
    drive(1'b0, 1'b1, 3'b000, 1'b0, 16'h1234);
    step();
    drive(1'b1, 1'b0, 3'b000, 1'b0, 16'h0016);
    step();
    check_outs("pre-reset", 16'h1234, 1'b0, 1'b0, 3'b000, 1'b1);
    idle();
    #2;
    n_p_reset29 = 1'b0;
    #1;
    check_outs("async reset", 16'd0, 1'b0, 1'b0, 3'b000, 1'b0);
    check("async reset ctrl", 32'(cntr_ctrl_reg_out29), 32'h1);
    step();
    n_p_reset29 = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      check($sformatf("post-reset stopped%0d", k), 32'(count_val_out29), 32'd0);
    end
    drive(1'b1, 1'b0, 3'b000, 1'b0, 16'h0000);
    step();
    check("enable edge count", 32'(count_val_out29), 32'd0);
    idle();
    step();
    check("first count after enable", 32'(count_val_out29), 32'd1);

    // Clock control 4'b0011: divide by 4 when prescaling is built in,
    // otherwise the strobe is ignored and every cycle ticks.
    drive(1'b0, 1'b0, 3'b000, 1'b1, 16'h0003);
    step();
    drive(1'b1, 1'b0, 3'b000, 1'b0, 16'h0010);
    step();
    check_outs("presc restart", 16'd0, 1'b0, 1'b0, 3'b000, 1'b1);
    idle();
    for (int k = 1; k <= 8; k++) begin
      step();
      check($sformatf("presc cycle%0d", k), 32'(count_val_out29), 32'(k / DIV));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ttc_counter_lite29.md
TTC_COUNTER_LITE29 -- requirements
Module: ttc_counter_lite29

Interface
REQ-001 SHALL have port pclk29, input, 1 bit, system clock; all state changes on its rising edge.
REQ-002 SHALL have port n_p_reset29, input, 1 bit, reset; asynchronous, active-low.
REQ-003 SHALL have port pwdata29, input, 16 bits, APB write data.
REQ-004 SHALL have port cntr_ctrl_reg_sel29, input, 1 bit, counter-control register write strobe.
REQ-005 SHALL have port interval_reg_sel29, input, 1 bit, interval register write strobe.
REQ-006 SHALL have port match_reg_sel29, input, 3 bits; bit n-1 is the match-n register write strobe (n = 1..3).
REQ-007 SHALL have port clk_ctrl_reg_sel29, input, 1 bit, clock-control register write strobe (used only with TTC_PRESCALE_EN).
REQ-008 SHALL have port interval_intr29, output, 1 bit, one-cycle interval pulse.
REQ-009 SHALL have port match_intr29, output, 3 bits [3:1], one-cycle match pulses.
REQ-010 SHALL have port overflow_intr29, output, 1 bit, one-cycle overflow pulse.
REQ-011 SHALL have port restart29, output, 1 bit, one-cycle restart pulse.
REQ-012 SHALL have port count_val_out29, output, 16 bits, current counter value.
REQ-013 SHALL have port cntr_ctrl_reg_out29, output, 4 bits, readback of control bits [3:0].

Function
REQ-014 SHALL define control bits: [0] disable (1 = stopped); [1] interval mode; [2] decrement; [3] match enable; [4] restart (write-only, self-clearing).
REQ-015 SHALL define limit as interval_reg in interval mode and 16'hFFFF otherwise.
REQ-016 SHALL advance the counter only on a tick cycle while disable = 0; a tick is every pclk29 unless prescaled (REQ-027).
REQ-017 Increment: at count = limit, a tick SHALL load 0; otherwise it SHALL load count+1.
REQ-018 Decrement: at count = 0, a tick SHALL load limit; otherwise it SHALL load count-1.
REQ-019 The wrap tick in REQ-017/018 SHALL pulse interval_intr29 in interval mode and overflow_intr29 otherwise, high for the single cycle after the wrapping edge.
REQ-020 When match enable = 1 and the newly loaded count equals match_n, match_intr29[n] SHALL pulse in the same cycle as the new count appears; equal match values SHALL pulse together.
REQ-021 A control write with bit4 = 1 SHALL, on the next edge:
- load count with 0 (increment) or limit (decrement);
- clear the prescaler;
- pulse restart29 for one cycle.
REQ-022 Restart SHALL win over a coincident tick, and no wrap or match pulse SHALL be generated on that edge.
REQ-023 Interval mode with interval_reg = 0 SHALL hold count at 0 and pulse interval_intr29 on every tick.
REQ-024 Register writes SHALL take effect on the edge after the strobe; a limit change SHALL NOT reload the count, and a count above a new limit SHALL run to 16'hFFFF and wrap.
REQ-025 While disabled, count and prescaler SHALL hold and no interrupt SHALL pulse; restart SHALL still act.

Reset
REQ-026 On n_p_reset29 low, all registers, count and outputs SHALL be 0, except disable, which SHALL be 1 (counter stopped).

Configuration
REQ-027 With macro TTC_PRESCALE_EN defined, SHALL implement a 4-bit clock-control register written from pwdata29[3:0]:
- bit0 = prescale enable;
- bits[3:1] = N;
- with prescale enabled, a tick SHALL occur every 2^(N+1) pclk29 cycles.
REQ-028 Without TTC_PRESCALE_EN, clk_ctrl_reg_sel29 SHALL be ignored and every pclk29 cycle SHALL be a tick.

Structure
REQ-029 SHALL place control-bit index constants, the 16'hFFFF limit and the prescale width in shared package ttc_lite_pkg29.
REQ-030 The prescaler SHALL be sub-module ttc_prescaler_lite29 (tick out, clear in); the counter and compare logic stay in the top.

Verification
REQ-031 Interval mode, interval = 3, increment, enable: count SHALL run 0,1,2,3,0 with interval_intr29 high one cycle after 3->0, then every 4 cycles.
REQ-032 Decrement, overflow mode, count at 0, one tick: count SHALL become 16'hFFFF and overflow_intr29 SHALL pulse once.
REQ-033 Match enable, match1 = 5, match3 = 5, increment from 0: match_intr29 SHALL equal 3'b101 for one cycle when count first reads 5.
REQ-034 Control write 5'b10000 on the same edge as a wrap tick: count SHALL be 0, restart29 SHALL pulse, and interval/overflow SHALL stay low.
REQ-035 TTC_PRESCALE_EN with clk_ctrl = 4'b0011 (N = 1): count SHALL advance once per 4 pclk29 cycles.
REQ-036 Reset asserted mid-count at 16'h1234: all outputs SHALL be 0 immediately, and the counter SHALL stay stopped after release until a control write.
